// File: rtl/dac_ddr_tx_pkg.sv
// Shared definitions for the DAC DDR transmit path.
//   tx_state_t    : sequencer state encoding (IDLE, SYNC, PRIME, RUN)
//   LANES_PER_SET : samples carried per sample set (A0, A1, B0, B1)
//   set_width()   : bit width of one sample set for a given sample width
//   idle_code()   : code driven to the DAC when no data is being sent
package dac_ddr_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } tx_state_t;

  localparam int LANES_PER_SET = 4;

  function automatic int set_width(input int nbits);
    return LANES_PER_SET * nbits;
  endfunction

  // Offset binary idles at midscale (MSB set); two's complement idles at zero.
  function automatic logic [31:0] idle_code(input int nbits, input bit twos_comp);
    logic [31:0] code;
    code = 32'd0;
    if (!twos_comp) code = 32'd1 << (nbits - 1);
    return code;
  endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// First-word-fall-through elastic FIFO built from a register array.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : empties the FIFO on the next edge; overrides push and pop
//   push/din : write one entry (ignored when full)
//   pop/dout : dout always shows the oldest entry; pop retires it (ignored when empty)
//   full, empty, level : occupancy status
module dac_tx_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dac_ddr_tx.sv
// DAC transmit sequencer: accepts two-phase sample sets for channels A and B,
// buffers them in an elastic FIFO and drives registered D1 (phase 0) / D2
// (phase 1) values towards the pin-level ODDR wrapper, plus the DAC sync strobe.
//   dac_clk, user_rst      : line clock, asynchronous active-high reset
//   user_enable            : level; low returns to IDLE and flushes the FIFO
//   user_sync              : one-cycle request to restart the sync sequence
//   s_valid/s_ready, s_*   : sample-set input handshake and samples
//   dac_da_*, dac_db_*     : registered samples to the ODDR D1/D2 inputs
//   dac_sync               : sync strobe, high for SYNC_CYCLES per sequence
//   tx_active              : high while in RUN
//   underflow/_clr         : sticky "FIFO ran dry in RUN" flag and its clear
//   fifo_level             : current FIFO occupancy
//
// Handshake: a sample set transfers on any rising edge where s_valid and
// s_ready are both high; s_ready depends only on state and FIFO fullness, never
// on s_valid. A transfer on an edge that also enters IDLE or SYNC is dropped.
module dac_ddr_tx
  import dac_ddr_tx_pkg::*;
#(
  parameter int NBITS       = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_CYCLES = 16,
  parameter int TWOS_COMP   = 0,
  // Occupancy that ends PRIME; valid range 1..FIFO_DEPTH.
  parameter int PRIME_LEVEL = FIFO_DEPTH / 2
) (
  input  logic                          dac_clk,
  input  logic                          user_rst,
  input  logic                          user_enable,
  input  logic                          user_sync,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NBITS-1:0]              s_da_0,
  input  logic [NBITS-1:0]              s_da_1,
  input  logic [NBITS-1:0]              s_db_0,
  input  logic [NBITS-1:0]              s_db_1,
  output logic [NBITS-1:0]              dac_da_0,
  output logic [NBITS-1:0]              dac_da_1,
  output logic [NBITS-1:0]              dac_db_0,
  output logic [NBITS-1:0]              dac_db_1,
  output logic                          dac_sync,
  output logic                          tx_active,
  output logic                          underflow,
  input  logic                          underflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SW = set_width(NBITS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(SYNC_CYCLES) + 1;

  localparam logic [NBITS-1:0] IDLE_CODE = NBITS'(idle_code(NBITS, TWOS_COMP != 0));
  localparam logic [SW-1:0]    IDLE_SET  = {LANES_PER_SET{IDLE_CODE}};
  // The entry edge already produces the first strobe cycle, so the counter
  // holds the number of strobe cycles still to come after the current one.
  localparam logic [CW-1:0]    SYNC_LOAD = CW'(SYNC_CYCLES - 1);

  tx_state_t     state;
  logic [CW-1:0] sync_cnt;
  logic [SW-1:0] dac_set;

  logic [SW-1:0] fifo_din;
  logic [SW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_cnt;

  logic resync;
  logic flush;
  logic accepting;
  logic push;
  logic pop;
  logic underflow_set;

  assign resync    = user_sync & (state != ST_IDLE);
  // Any edge that lands in IDLE or (re)enters SYNC empties the buffer.
  assign flush     = ~user_enable | resync | (state == ST_IDLE);
  assign accepting = (state == ST_PRIME) | (state == ST_RUN);
  assign s_ready   = accepting & ~fifo_full;
  assign push      = s_valid & s_ready & ~flush;
  assign pop       = (state == ST_RUN) & ~flush;
  // Only an edge that stays in RUN with nothing to send counts as underflow.
  assign underflow_set = (state == ST_RUN) & user_enable & ~resync & fifo_empty;

  assign fifo_din   = {s_da_0, s_da_1, s_db_0, s_db_1};
  assign fifo_level = fifo_cnt;

  dac_tx_fifo #(
    .W     (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (dac_clk),
    .rst   (user_rst),
    .flush (flush),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_cnt)
  );

  always_ff @(posedge dac_clk or posedge user_rst) begin
    if (user_rst) begin
      state     <= ST_IDLE;
      sync_cnt  <= '0;
      dac_set   <= IDLE_SET;
      dac_sync  <= 1'b0;
      tx_active <= 1'b0;
    end else begin
      dac_set   <= IDLE_SET;
      dac_sync  <= 1'b0;
      tx_active <= 1'b0;
      if (!user_enable) begin
        state <= ST_IDLE;
      end else if (resync) begin
        state    <= ST_SYNC;
        sync_cnt <= SYNC_LOAD;
        dac_sync <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_SYNC;
            sync_cnt <= SYNC_LOAD;
            dac_sync <= 1'b1;
          end
          ST_SYNC: begin
            if (sync_cnt != '0) begin
              sync_cnt <= sync_cnt - CW'(1);
              dac_sync <= 1'b1;
            end else begin
              state <= ST_PRIME;
            end
          end
          ST_PRIME: begin
            if (fifo_cnt >= LW'(PRIME_LEVEL)) begin
              state     <= ST_RUN;
              tx_active <= 1'b1;
            end
          end
          ST_RUN: begin
            tx_active <= 1'b1;
            if (!fifo_empty) dac_set <= fifo_dout;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Set wins over clear so an underflow in the clearing cycle is not lost.
  always_ff @(posedge dac_clk or posedge user_rst) begin
    if (user_rst) begin
      underflow <= 1'b0;
    end else if (underflow_set) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  assign dac_da_0 = dac_set[SW-1 -: NBITS];
  assign dac_da_1 = dac_set[SW-NBITS-1 -: NBITS];
  assign dac_db_0 = dac_set[2*NBITS-1 -: NBITS];
  assign dac_db_1 = dac_set[NBITS-1:0];

endmodule

// File: tb/tb_dac_ddr_tx.sv
`timescale 1ns/1ps
module tb_dac_ddr_tx;

  localparam int NBITS = 12;
  localparam int DEPTH = 8;
  localparam int SYNCN = 16;
  localparam int SW    = 4 * NBITS;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [NBITS-1:0] IDLE     = 12'h800;
  localparam logic [SW-1:0]    IDLE_SET = {4{IDLE}};

  // Reference modes of the sequencer
  localparam int M_OFF = 0, M_SYNC = 1, M_PRIME = 2, M_RUN = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en = 1'b0, sy = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [NBITS-1:0] in_da0 = '0, in_da1 = '0, in_db0 = '0, in_db1 = '0;

  logic             rdy   [2];
  logic [NBITS-1:0] da0   [2];
  logic [NBITS-1:0] da1   [2];
  logic [NBITS-1:0] db0   [2];
  logic [NBITS-1:0] db1   [2];
  logic             dsync [2];
  logic             act   [2];
  logic             uf    [2];
  logic [LW-1:0]    lvl   [2];

  // Instance 0: default priming threshold (half full).
  dac_ddr_tx #(.NBITS(NBITS), .FIFO_DEPTH(DEPTH), .SYNC_CYCLES(SYNCN), .TWOS_COMP(0)) u0 (
    .dac_clk(clk), .user_rst(rst), .user_enable(en), .user_sync(sy),
    .s_valid(valid), .s_ready(rdy[0]),
    .s_da_0(in_da0), .s_da_1(in_da1), .s_db_0(in_db0), .s_db_1(in_db1),
    .dac_da_0(da0[0]), .dac_da_1(da1[0]), .dac_db_0(db0[0]), .dac_db_1(db1[0]),
    .dac_sync(dsync[0]), .tx_active(act[0]), .underflow(uf[0]),
    .underflow_clr(clr), .fifo_level(lvl[0])
  );

  // Instance 1: primes all the way to full, exercising backpressure.
  dac_ddr_tx #(.NBITS(NBITS), .FIFO_DEPTH(DEPTH), .SYNC_CYCLES(SYNCN), .TWOS_COMP(0),
               .PRIME_LEVEL(DEPTH)) u1 (
    .dac_clk(clk), .user_rst(rst), .user_enable(en), .user_sync(sy),
    .s_valid(valid), .s_ready(rdy[1]),
    .s_da_0(in_da0), .s_da_1(in_da1), .s_db_0(in_db0), .s_db_1(in_db1),
    .dac_da_0(da0[1]), .dac_da_1(da1[1]), .dac_db_0(db0[1]), .dac_db_1(db1[1]),
    .dac_sync(dsync[1]), .tx_active(act[1]), .underflow(uf[1]),
    .underflow_clr(clr), .fifo_level(lvl[1])
  );

  // ---------------- reference model ----------------
  int          checks   = 0;
  int          failures = 0;
  int          m_mode [2];
  int          m_left [2];
  logic [SW-1:0] m_out [2];
  bit          m_sync [2];
  bit          m_act  [2];
  bit          m_uf   [2];
  logic [SW-1:0] exp_q0[$];
  logic [SW-1:0] exp_q1[$];

  function automatic int prime_level(input int i);
    return (i == 0) ? DEPTH / 2 : DEPTH;
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_clear(input int i);
    if (i == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  task automatic q_push(input int i, input logic [SW-1:0] v);
    if (i == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  function automatic logic [SW-1:0] q_pop(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic bit model_ready(input int i);
    return (m_mode[i] == M_PRIME || m_mode[i] == M_RUN) && q_size(i) < DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_OFF; m_left[i] = 0; m_out[i] = IDLE_SET;
      m_sync[i] = 0; m_act[i] = 0; m_uf[i] = 0;
      q_clear(i);
    end
  endtask

  // One rising edge of behaviour, computed from the inputs present before it.
  task automatic model_step();
    logic [SW-1:0] din;
    bit acc, set_uf;
    din = {in_da0, in_da1, in_db0, in_db1};
    for (int i = 0; i < 2; i++) begin
      acc = valid && model_ready(i);
      set_uf = 0;
      m_out[i] = IDLE_SET; m_sync[i] = 0; m_act[i] = 0;
      if (!en) begin
        m_mode[i] = M_OFF;
        q_clear(i);
      end else if (sy && m_mode[i] != M_OFF) begin
        m_mode[i] = M_SYNC; m_left[i] = SYNCN; m_sync[i] = 1;
        q_clear(i);
      end else begin
        case (m_mode[i])
          M_OFF: begin
            m_mode[i] = M_SYNC; m_left[i] = SYNCN; m_sync[i] = 1;
          end
          M_SYNC: begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_mode[i] = M_PRIME;
            else m_sync[i] = 1;
          end
          M_PRIME: begin
            if (q_size(i) >= prime_level(i)) begin
              m_mode[i] = M_RUN; m_act[i] = 1;
            end
            if (acc) q_push(i, din);
          end
          default: begin
            m_act[i] = 1;
            if (q_size(i) > 0) m_out[i] = q_pop(i);
            else set_uf = 1;
            if (acc) q_push(i, din);
          end
        endcase
      end
      if (set_uf) m_uf[i] = 1;
      else if (clr) m_uf[i] = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.dac_da_0", i), 64'(da0[i]), 64'(m_out[i][SW-1 -: NBITS]));
      chk($sformatf("u%0d.dac_da_1", i), 64'(da1[i]), 64'(m_out[i][SW-NBITS-1 -: NBITS]));
      chk($sformatf("u%0d.dac_db_0", i), 64'(db0[i]), 64'(m_out[i][2*NBITS-1 -: NBITS]));
      chk($sformatf("u%0d.dac_db_1", i), 64'(db1[i]), 64'(m_out[i][NBITS-1:0]));
      chk($sformatf("u%0d.dac_sync", i), 64'(dsync[i]), 64'(m_sync[i]));
      chk($sformatf("u%0d.tx_active", i), 64'(act[i]), 64'(m_act[i]));
      chk($sformatf("u%0d.underflow", i), 64'(uf[i]), 64'(m_uf[i]));
      chk($sformatf("u%0d.s_ready", i), 64'(rdy[i]), 64'(model_ready(i)));
      chk($sformatf("u%0d.fifo_level", i), 64'(lvl[i]), 64'(q_size(i)));
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.dac_da_0", tag, i), 64'(da0[i]), 64'(IDLE));
      chk($sformatf("%s.u%0d.dac_db_1", tag, i), 64'(db1[i]), 64'(IDLE));
      chk($sformatf("%s.u%0d.dac_sync", tag, i), 64'(dsync[i]), 64'd0);
      chk($sformatf("%s.u%0d.tx_active", tag, i), 64'(act[i]), 64'd0);
      chk($sformatf("%s.u%0d.underflow", tag, i), 64'(uf[i]), 64'd0);
      chk($sformatf("%s.u%0d.s_ready", tag, i), 64'(rdy[i]), 64'd0);
      chk($sformatf("%s.u%0d.fifo_level", tag, i), 64'(lvl[i]), 64'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [NBITS-1:0] ramp = 12'h001;

  task automatic drive(input bit v);
    valid = v;
    if (v) begin
      in_da0 = ramp;
      ramp   = ramp + 12'h001;
      in_da1 = NBITS'($urandom);
      in_db0 = NBITS'($urandom);
      in_db1 = NBITS'($urandom);
    end
  endtask

  // Edge, model update, then check on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  int sync_high;
  logic [NBITS-1:0] probe;

  initial begin
    model_reset();
    repeat (3) cycle();
    check_reset_values("reset");
    rst = 1'b0;

    // Disabled: everything idles.
    repeat (20) cycle();
    check_reset_values("idle");

    // Enable: count the strobe width.
    en = 1'b1;
    sync_high = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (dsync[0]) sync_high++;
    end
    chk("sync_width", 64'(sync_high), 64'(SYNCN));
    chk("prime_ready", 64'(rdy[0]), 64'd1);

    // Continuous ramp: primes, runs, instance 1 fills to full first.
    for (int k = 0; k < 40; k++) begin
      drive(1'b1);
      cycle();
    end
    chk("run_active", 64'(act[0]), 64'd1);

    // Drain to underflow.
    drive(1'b0);
    repeat (15) cycle();
    chk("underflow_set", 64'(uf[0]), 64'd1);
    chk("drained_idle", 64'(da0[0]), 64'(IDLE));

    // Clear while still empty: set dominates.
    clr = 1'b1;
    cycle();
    chk("clr_while_empty", 64'(uf[0]), 64'd1);
    clr = 1'b0;

    // Single write: minimum latency of two edges; clear on the popping edge.
    drive(1'b1);
    probe = in_da0;
    cycle();
    chk("lat_edge1", 64'(da0[0]), 64'(IDLE));
    drive(1'b0);
    clr = 1'b1;
    cycle();
    chk("lat_edge2", 64'(da0[0]), 64'(probe));
    chk("clr_nonempty", 64'(uf[0]), 64'd0);
    clr = 1'b0;

    // Random traffic with occasional clears.
    for (int k = 0; k < 120; k++) begin
      drive(1'($urandom_range(0, 1)));
      clr = ($urandom_range(0, 7) == 0);
      cycle();
    end
    clr = 1'b0;

    // Resync, then refill so instance 0 sits at level 5 in RUN.
    drive(1'b0);
    sy = 1'b1;
    cycle();
    sy = 1'b0;
    repeat (20) cycle();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1);
      cycle();
    end
    chk("run_level5", 64'(lvl[0]), 64'd5);

    // Resync with a concurrent write: write dropped, FIFO flushed.
    drive(1'b1);
    sy = 1'b1;
    cycle();
    sy = 1'b0;
    drive(1'b0);
    chk("resync_flush", 64'(lvl[0]), 64'd0);
    chk("resync_strobe", 64'(dsync[0]), 64'd1);
    repeat (5) cycle();

    // Asynchronous reset in the middle of the strobe burst.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_values("async_rst");
    repeat (2) cycle();
    rst = 1'b0;

    // Recover, run a little, then drop enable with data still flowing.
    for (int k = 0; k < 30; k++) begin
      drive(1'b1);
      cycle();
    end
    en = 1'b0;
    cycle();
    chk("disable_flush", 64'(lvl[0]), 64'd0);
    drive(1'b0);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
